// File: rtl/display_7seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : display_7seg_scan_ctrl
//  Brief    : Bus-mapped, time-multiplexed scan controller for an N-digit
//             common-anode 7-segment display (nibble, anode, dp per slot).
//  Revision : 1.0  initial release
// ============================================================================
module display_7seg_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  num,
    output logic [7:0]  an,
    output logic        dp
);

    localparam int                c_CNT_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0] c_BLANK    = c_CNT_W'(BLANK_CYCLES);
    localparam logic [2:0]        c_IDX_LAST = 3'(N_DIGITS - 1);

    logic [31:0]        r_data;
    logic [7:0]         r_mask;
    logic [7:0]         r_dpm;
    logic               r_en;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_idx;
    logic [7:0]         r_an;
    logic               r_dp;
    logic [3:0]         r_num;

    logic [7:0]         w_an_next;
    logic               w_active;
    logic [3:0]         w_num_next;

    always_comb begin
        rdata = 32'h0;
        case (addr)
            2'd0:    rdata = r_data;
            2'd1:    rdata = {15'h0, r_en, r_dpm, r_mask};
            default: rdata = 32'h0;
        endcase
    end

    // Blanking at the start of each slot hides ghosting while the decoder settles.
    always_comb begin
        w_active   = (r_cnt >= c_BLANK) && r_en && r_mask[r_idx];
        w_an_next  = 8'hFF;
        if (w_active) begin
            w_an_next[r_idx] = 1'b0;
        end
        w_num_next = r_data[{r_idx, 2'b00} +: 4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= 32'h0;
            r_mask <= 8'hFF;
            r_dpm  <= 8'h00;
            r_en   <= 1'b1;
            r_cnt  <= '0;
            r_idx  <= 3'd0;
            r_an   <= 8'hFF;
            r_dp   <= 1'b1;
            r_num  <= 4'h0;
        end else begin
            if (we && addr == 2'd0) begin
                r_data <= wdata;
            end
            if (we && addr == 2'd1) begin
                r_mask <= wdata[7:0];
                r_dpm  <= wdata[15:8];
                r_en   <= wdata[16];
            end

            // Scan keeps running regardless of enables so duty cycle never shifts.
            if (r_cnt == c_CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == c_IDX_LAST) ? 3'd0 : r_idx + 3'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            r_an  <= w_an_next;
            r_dp  <= ~(r_dpm[r_idx] & w_active);
            r_num <= w_num_next;
        end
    end

    assign an  = r_an;
    assign dp  = r_dp;
    assign num = r_num;

endmodule
`default_nettype wire

// File: tb/tb_display_7seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_7seg_scan_ctrl
//  Brief    : Directed self-checking bench for display_7seg_scan_ctrl
//             (8 digits, 4-cycle slots, 1 blank cycle).
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_7seg_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  num;
    logic [7:0]  an;
    logic        dp;

    int vectors;
    int miscompares;

    // Expected register contents and the scan position the next edge will display.
    logic [31:0] e_data;
    logic [7:0]  e_mask;
    logic [7:0]  e_dpm;
    logic        e_en;
    int          p_idx;
    int          p_cnt;

    display_7seg_scan_ctrl #(
        .N_DIGITS    (8),
        .PRESCALE    (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .addr (addr),
        .wdata(wdata),
        .rdata(rdata),
        .num  (num),
        .an   (an),
        .dp   (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic note_timeout(input string tag);
        vectors++;
        miscompares++;
        $error("FAIL %s: observed timeout expected scan position reached", tag);
    endtask

    // One clock edge, then check outputs against the slot the edge should show.
    task automatic tick();
        logic [7:0] xan;
        logic       xdp;
        logic [3:0] xnum;
        @(posedge clk);
        #1;
        if (rst) begin
            xan  = 8'hFF;
            xdp  = 1'b1;
            xnum = 4'h0;
        end else begin
            xnum = e_data[p_idx*4 +: 4];
            xan  = 8'hFF;
            if (p_cnt >= 1 && e_en && e_mask[p_idx]) xan[p_idx] = 1'b0;
            xdp  = !(e_dpm[p_idx] && !xan[p_idx]);
        end
        chk("an", {24'h0, an}, {24'h0, xan});
        chk("dp", {31'h0, dp}, {31'h0, xdp});
        chk("num", {28'h0, num}, {28'h0, xnum});
        if (rst) begin
            e_data = 32'h0;
            e_mask = 8'hFF;
            e_dpm  = 8'h00;
            e_en   = 1'b1;
            p_idx  = 0;
            p_cnt  = 0;
        end else begin
            if (we && addr == 2'd0) e_data = wdata;
            if (we && addr == 2'd1) begin
                e_mask = wdata[7:0];
                e_dpm  = wdata[15:8];
                e_en   = wdata[16];
            end
            p_cnt++;
            if (p_cnt == 4) begin
                p_cnt = 0;
                p_idx = (p_idx + 1) % 8;
            end
        end
    endtask

    initial begin
        int guard;
        vectors     = 0;
        miscompares = 0;
        rst   = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 32'h0;
        e_data = 32'h0;
        e_mask = 8'hFF;
        e_dpm  = 8'h00;
        e_en   = 1'b1;
        p_idx  = 0;
        p_cnt  = 0;

        // Reset state and register read-back (enable bit resets to 1).
        tick();
        tick();
        addr = 2'd1; #1;
        chk("rst_ctrl", rdata, 32'h0001_00FF);
        addr = 2'd0; #1;
        chk("rst_data", rdata, 32'h0);

        // Scan order over nine slots, including the wrap from digit 7 to 0.
        rst = 1'b0; we = 1'b1; addr = 2'd0; wdata = 32'h7654_3210;
        tick();
        we = 1'b0;
        repeat (35) tick();

        // Digits 4..7 masked, then global enable off.
        we = 1'b1; addr = 2'd1; wdata = 32'h0001_000F;
        tick();
        we = 1'b0; #1;
        chk("ctrl_rb", rdata, 32'h0001_000F);
        repeat (32) tick();
        we = 1'b1; wdata = 32'h0000_00FF;
        tick();
        we = 1'b0;
        repeat (32) tick();

        // Decimal point on digit 2 only.
        we = 1'b1; wdata = 32'h0001_04FF;
        tick();
        we = 1'b0;
        repeat (32) tick();

        // Mid-slot write during digit 3.
        guard = 0;
        while (!(p_idx == 3 && p_cnt == 2) && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) note_timeout("wait_digit3");
        we = 1'b1; addr = 2'd0; wdata = 32'hFEDC_BA98;
        tick();
        chk("num_before_wr", {28'h0, num}, 32'h3);
        we = 1'b0;
        tick();
        chk("num_after_wr", {28'h0, num}, 32'hB);

        // Writes to an unused address change nothing.
        we = 1'b1; addr = 2'd2; wdata = 32'hFFFF_FFFF;
        tick();
        we = 1'b0; addr = 2'd0; #1;
        chk("data_after_bad", rdata, 32'hFEDC_BA98);
        addr = 2'd1; #1;
        chk("ctrl_after_bad", rdata, 32'h0001_04FF);
        addr = 2'd3; #1;
        chk("rd_addr3", rdata, 32'h0);
        addr = 2'd2; #1;
        chk("rd_addr2", rdata, 32'h0);
        addr = 2'd0;
        repeat (6) tick();

        // Reset mid-scan during digit 5.
        guard = 0;
        while (!(p_idx == 5 && p_cnt == 2) && guard < 40) begin
            tick();
            guard++;
        end
        if (guard >= 40) note_timeout("wait_digit5");
        rst = 1'b1;
        tick();
        chk("an_at_rst", {24'h0, an}, 32'hFF);
        #1;
        chk("data_at_rst", rdata, 32'h0);
        rst = 1'b0;
        tick();
        chk("an_blank_after_rst", {24'h0, an}, 32'hFF);
        tick();
        chk("an_first_active", {24'h0, an}, 32'hFE);
        repeat (8) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
